// File: rtl/router_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : router_reg_if
// Description : Bundle of the byte stream, FIFO status, FSM state strobes and
//               register-block results exchanged with router_reg.
//               master : FSM/source side (drives stream and strobes)
//               slave  : router_reg side (drives dout, parity_done,
//                        lowpktvalid, err)
// Revision    : 1.0 - initial release
// ============================================================================
interface router_reg_if;
  logic       pktvalid;     // source byte valid; low on the parity byte
  logic [7:0] datain;       // header, payload, parity byte stream
  logic       fifofull;     // selected destination FIFO full
  logic       detect_add;   // FSM state strobes (expected one-hot)
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [7:0] dout;         // byte to the destination FIFO
  logic       parity_done;  // packet parity byte captured
  logic       lowpktvalid;  // pktvalid fell while loading
  logic       err;          // parity mismatch for the completed packet

  modport master (
    output pktvalid, datain, fifofull,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  dout, parity_done, lowpktvalid, err
  );

  modport slave (
    input  pktvalid, datain, fifofull,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, lowpktvalid, err
  );
endinterface
`default_nettype wire

// File: rtl/router_reg.sv
`default_nettype none
// ============================================================================
// Module      : router_reg
// Description : Router register block. Latches the packet header, forwards
//               header/payload/parity bytes to the destination FIFO, holds the
//               byte a full FIFO refused, accumulates the running XOR parity
//               and flags a mismatch against the received parity byte.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - router_reg_if.slave (stream, strobes, results)
// Revision    : 1.0 - initial release
// ============================================================================
module router_reg (
  input  wire logic   clk,
  input  wire logic   rst,
  router_reg_if.slave bus
);

  logic [7:0] r_hdr;
  logic [7:0] r_hold_byte;
  logic [7:0] r_int_parity;
  logic [7:0] r_pkt_parity;
  logic [7:0] r_dout;
  logic       r_parity_done;
  logic       r_lowpktvalid;
  logic       r_err;

  // Address 2'b11 is not a destination: such a detect_add cycle leaves every
  // register alone instead of starting a new packet.
  logic w_bad_addr;
  logic w_det_clr;
  logic w_hdr_cap;
  logic w_par_cap_ld;
  logic w_par_cap_laf;
  logic w_unused_full;

  assign w_bad_addr    = bus.detect_add & bus.pktvalid & (bus.datain[1:0] == 2'b11);
  assign w_det_clr     = bus.detect_add & ~w_bad_addr;
  assign w_hdr_cap     = bus.detect_add & bus.pktvalid & (bus.datain[1:0] != 2'b11);
  // Parity byte arrives either directly (FIFO ready) or, if the FIFO was full
  // when it arrived, from the hold register during the after-full state.
  assign w_par_cap_ld  = bus.ld_state & ~bus.pktvalid & ~bus.fifofull;
  assign w_par_cap_laf = bus.laf_state & r_lowpktvalid & ~r_parity_done;

  // full_state only stalls the FSM; the data path simply holds.
  assign w_unused_full = bus.full_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hdr <= 8'h00;
    end else if (w_hdr_cap) begin
      r_hdr <= bus.datain;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= 8'h00;
    end else if (bus.lfd_state) begin
      r_dout <= r_hdr;
    end else if (bus.ld_state & ~bus.fifofull) begin
      r_dout <= bus.datain;
    end else if (bus.laf_state) begin
      r_dout <= r_hold_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_byte <= 8'h00;
    end else if (bus.ld_state & bus.fifofull) begin
      r_hold_byte <= bus.datain;
    end
  end

  // Running parity over header and payload. The held byte is folded in only
  // when it is payload; when lowpktvalid is set it is the parity byte itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_parity <= 8'h00;
    end else if (bus.detect_add) begin
      if (w_det_clr) begin
        r_int_parity <= 8'h00;
      end
    end else if (bus.lfd_state) begin
      r_int_parity <= r_int_parity ^ r_hdr;
    end else if (bus.ld_state & bus.pktvalid & ~bus.fifofull) begin
      r_int_parity <= r_int_parity ^ bus.datain;
    end else if (bus.laf_state & ~r_lowpktvalid) begin
      r_int_parity <= r_int_parity ^ r_hold_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_parity <= 8'h00;
    end else if (w_par_cap_ld) begin
      r_pkt_parity <= bus.datain;
    end else if (w_par_cap_laf) begin
      r_pkt_parity <= r_hold_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity_done <= 1'b0;
    end else if (w_det_clr) begin
      r_parity_done <= 1'b0;
    end else if (w_par_cap_ld | w_par_cap_laf) begin
      r_parity_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lowpktvalid <= 1'b0;
    end else if (bus.ld_state & ~bus.pktvalid) begin
      r_lowpktvalid <= 1'b1;
    end else if (bus.rst_int_reg) begin
      r_lowpktvalid <= 1'b0;
    end
  end

  // The next packet's detect_add must win over the compare, otherwise the
  // still-set parity_done would re-assert err in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_det_clr) begin
      r_err <= 1'b0;
    end else if (r_parity_done) begin
      r_err <= (r_int_parity != r_pkt_parity);
    end
  end

  assign bus.dout        = r_dout;
  assign bus.parity_done = r_parity_done;
  assign bus.lowpktvalid = r_lowpktvalid;
  assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_router_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_reg
// Description : Self-checking bench for router_reg. Plays whole packets the
//               way the router FSM sequences its strobes, with random payloads
//               and random FIFO stalls, and checks the FIFO byte stream and
//               parity result against a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_reg;

  logic clk;
  logic rst;
  router_reg_if bus ();

  router_reg u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec;
  int         n_err;
  logic [7:0] exp_dout;   // last byte the FIFO should have received
  logic [7:0] last_hdr;   // last accepted header
  logic [7:0] q_pl[$];    // payload of the packet about to be sent

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pktvalid    = 1'b0;
    bus.datain      = 8'h00;
    bus.fifofull    = 1'b0;
    bus.detect_add  = 1'b0;
    bus.lfd_state   = 1'b0;
    bus.ld_state    = 1'b0;
    bus.laf_state   = 1'b0;
    bus.full_state  = 1'b0;
    bus.rst_int_reg = 1'b0;
  endtask

  // One full packet: header, payload from q_pl, parity byte. stall[i] makes
  // the FIFO refuse payload byte i once; stall_par does the same for parity.
  task automatic run_packet(input logic [7:0] h, input logic [7:0] par,
                            input logic [15:0] stall, input logic stall_par);
    logic [7:0] calc;
    logic       exp_err;
    calc = h;
    foreach (q_pl[i]) calc = calc ^ q_pl[i];
    exp_err = (calc != par);

    idle(); bus.detect_add = 1'b1; bus.pktvalid = 1'b1; bus.datain = h; step();
    n_vec++;
    if (bus.parity_done !== 1'b0 || bus.err !== 1'b0 || bus.dout !== exp_dout) begin
      n_err++;
      $display("FAIL detect_clear: pd=%b err=%b dout=%h expected pd=0 err=0 dout=%h",
               bus.parity_done, bus.err, bus.dout, exp_dout);
    end
    last_hdr = h;

    idle(); bus.lfd_state = 1'b1; step();
    exp_dout = h;
    n_vec++;
    if (bus.dout !== exp_dout) begin
      n_err++;
      $display("FAIL header_out: dout=%h expected %h", bus.dout, exp_dout);
    end

    foreach (q_pl[i]) begin
      idle(); bus.ld_state = 1'b1; bus.pktvalid = 1'b1; bus.datain = q_pl[i];
      if (stall[i]) begin
        bus.fifofull = 1'b1; step();
        n_vec++;
        if (bus.dout !== exp_dout) begin
          n_err++;
          $display("FAIL stall_hold: dout=%h expected %h", bus.dout, exp_dout);
        end
        idle(); bus.laf_state = 1'b1; step();
      end else begin
        step();
      end
      exp_dout = q_pl[i];
      n_vec++;
      if (bus.dout !== exp_dout) begin
        n_err++;
        $display("FAIL payload_out[%0d]: dout=%h expected %h", i, bus.dout, exp_dout);
      end
    end

    idle(); bus.ld_state = 1'b1; bus.datain = par; bus.fifofull = stall_par; step();
    if (!stall_par) exp_dout = par;
    n_vec++;
    if (bus.lowpktvalid !== 1'b1 || bus.dout !== exp_dout || bus.parity_done !== !stall_par) begin
      n_err++;
      $display("FAIL parity_byte: lowpkt=%b dout=%h pd=%b expected lowpkt=1 dout=%h pd=%b",
               bus.lowpktvalid, bus.dout, bus.parity_done, exp_dout, !stall_par);
    end
    if (stall_par) begin
      idle(); bus.laf_state = 1'b1; step();
      exp_dout = par;
      n_vec++;
      if (bus.dout !== exp_dout || bus.parity_done !== 1'b1) begin
        n_err++;
        $display("FAIL parity_after_full: dout=%h pd=%b expected dout=%h pd=1",
                 bus.dout, bus.parity_done, exp_dout);
      end
    end

    idle(); step();
    n_vec++;
    if (bus.err !== exp_err || bus.parity_done !== 1'b1) begin
      n_err++;
      $display("FAIL err_flag: err=%b pd=%b expected err=%b pd=1",
               bus.err, bus.parity_done, exp_err);
    end

    idle(); bus.rst_int_reg = 1'b1; step();
    n_vec++;
    if (bus.lowpktvalid !== 1'b0) begin
      n_err++;
      $display("FAIL lowpkt_clear: lowpkt=%b expected 0", bus.lowpktvalid);
    end
    idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    step(); step();
    n_vec++;
    if (bus.dout !== 8'h00 || bus.parity_done !== 1'b0 ||
        bus.lowpktvalid !== 1'b0 || bus.err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: dout=%h pd=%b lowpkt=%b err=%b expected all 0",
               bus.dout, bus.parity_done, bus.lowpktvalid, bus.err);
    end
    #3 rst = 1'b0;
    exp_dout = 8'h00;
    last_hdr = 8'h00;
  endtask

  task automatic test_clean_packet();
    q_pl = '{8'hA1};
    run_packet(8'h05, 8'hA4, 16'h0000, 1'b0);
  endtask

  task automatic test_bad_parity();
    q_pl = '{8'hA1};
    run_packet(8'h05, 8'hFF, 16'h0000, 1'b0);
  endtask

  task automatic test_fifo_full();
    // 3C stalls once; parity 06^3C^11 = 2B proves 3C counted exactly once.
    q_pl = '{8'h3C, 8'h11};
    run_packet(8'h06, 8'h2B, 16'h0001, 1'b0);
    // Parity byte itself refused by a full FIFO.
    q_pl = '{8'hA1};
    run_packet(8'h05, 8'hA4, 16'h0000, 1'b1);
  endtask

  task automatic test_invalid_addr();
    logic pd_before;
    logic err_before;
    pd_before  = bus.parity_done;
    err_before = bus.err;
    idle(); bus.detect_add = 1'b1; bus.pktvalid = 1'b1; bus.datain = 8'h07; step();
    n_vec++;
    if (bus.dout !== exp_dout || bus.parity_done !== pd_before || bus.err !== err_before) begin
      n_err++;
      $display("FAIL invalid_addr: dout=%h pd=%b err=%b expected dout=%h pd=%b err=%b",
               bus.dout, bus.parity_done, bus.err, exp_dout, pd_before, err_before);
    end
    idle(); bus.lfd_state = 1'b1; step();
    exp_dout = last_hdr;
    n_vec++;
    if (bus.dout !== exp_dout) begin
      n_err++;
      $display("FAIL invalid_hdr_kept: dout=%h expected %h", bus.dout, exp_dout);
    end
    idle();
  endtask

  task automatic test_async_reset();
    // Bad-parity packet leaves parity_done and err set.
    q_pl = '{8'h10, 8'h20};
    run_packet(8'h01, 8'h00, 16'h0000, 1'b0);
    // Parity byte refused: lowpktvalid up, hold register loaded.
    idle(); bus.ld_state = 1'b1; bus.fifofull = 1'b1; bus.datain = 8'h33; step();
    idle();
    n_vec++;
    if (bus.lowpktvalid !== 1'b1 || bus.parity_done !== 1'b1 || bus.err !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_state: lowpkt=%b pd=%b err=%b expected 1 1 1",
               bus.lowpktvalid, bus.parity_done, bus.err);
    end
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.dout !== 8'h00 || bus.parity_done !== 1'b0 ||
        bus.lowpktvalid !== 1'b0 || bus.err !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: dout=%h pd=%b lowpkt=%b err=%b expected all 0",
               bus.dout, bus.parity_done, bus.lowpktvalid, bus.err);
    end
    step();
    #3 rst = 1'b0;
    exp_dout = 8'h00;
    // Zeroed header, hold byte and parities must show through.
    idle(); bus.lfd_state = 1'b1; step();
    idle(); bus.laf_state = 1'b1; step();
    n_vec++;
    if (bus.dout !== 8'h00) begin
      n_err++;
      $display("FAIL reset_regs_zero: dout=%h expected 00", bus.dout);
    end
    idle(); bus.ld_state = 1'b1; bus.datain = 8'h00; step();
    idle(); step();
    n_vec++;
    if (bus.parity_done !== 1'b1 || bus.err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_parity_zero: pd=%b err=%b expected pd=1 err=0",
               bus.parity_done, bus.err);
    end
    idle(); bus.rst_int_reg = 1'b1; step();
    idle();
  endtask

  task automatic test_random();
    for (int p = 0; p < 24; p++) begin
      logic [7:0]  h;
      logic [7:0]  calc;
      logic [7:0]  par;
      logic [15:0] stall;
      int          len;
      h   = {6'($urandom), 2'($urandom_range(0, 2))};
      len = $urandom_range(1, 8);
      q_pl.delete();
      calc = h;
      for (int i = 0; i < len; i++) begin
        q_pl.push_back(8'($urandom));
        calc = calc ^ q_pl[i];
      end
      par   = ($urandom_range(0, 1) == 1) ? calc : 8'($urandom);
      stall = 16'($urandom);
      run_packet(h, par, stall, 1'($urandom));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_clean_packet();
    test_bad_parity();
    test_fifo_full();
    test_invalid_addr();
    test_random();
    test_async_reset();
    test_clean_packet();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_reg.md
ROUTER_REG -- requirements
Module: router_reg

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high. Ports: clk, rst.
REQ-002 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  in  1  async active-high reset.
REQ-004 SHALL have port pktvalid  in  1  source byte valid; low on the parity byte.
REQ-005 SHALL have port datain  in  8  packet byte stream (header, payload, parity).
REQ-006 SHALL have port fifofull  in  1  selected destination FIFO full.
REQ-007 SHALL have ports detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  in  1 each  one-hot state strobes from the router FSM.
REQ-008 SHALL have port dout  out  8  byte to the destination FIFO.
REQ-009 SHALL have port parity_done  out  1  packet parity byte captured.
REQ-010 SHALL have port lowpktvalid  out  1  pktvalid fell while in load state.
REQ-011 SHALL have port err  out  1  parity mismatch for the completed packet.

Function
REQ-012 SHALL hold internal registers: hdr (8), hold_byte (8), int_parity (8), pkt_parity (8).
REQ-013 SHALL capture hdr <= datain when detect_add & pktvalid & datain[1:0] != 2'b11; otherwise hdr holds.
REQ-014 SHALL update dout, priority order: lfd_state -> dout <= hdr; ld_state & !fifofull -> dout <= datain; laf_state -> dout <= hold_byte; else dout holds.
REQ-015 SHALL capture hold_byte <= datain when ld_state & fifofull; else hold (the byte the FIFO could not accept).
REQ-016 SHALL clear int_parity when detect_add; lfd_state -> int_parity ^= hdr; ld_state & pktvalid & !fifofull -> int_parity ^= datain; laf_state & !lowpktvalid -> int_parity ^= hold_byte.
REQ-017 SHALL capture pkt_parity <= datain when ld_state & !pktvalid & !fifofull; pkt_parity <= hold_byte when laf_state & lowpktvalid & !parity_done.
REQ-018 SHALL set parity_done on either REQ-017 capture condition; clear it when detect_add; else hold.
REQ-019 SHALL set lowpktvalid when ld_state & !pktvalid; clear when rst_int_reg; set wins if both in one cycle.
REQ-020 SHALL, in any cycle with parity_done = 1, register err <= (int_parity != pkt_parity); clear err when detect_add; else hold. err is valid one cycle after parity_done rises.
REQ-021 SHALL ignore full_state for data path (dout, hold_byte, parities hold while full_state).
REQ-022 SHALL treat header address 2'b11 as invalid: hdr, int_parity unchanged, no output change.
REQ-023 SHALL not depend on strobes being one-hot; if several assert, REQ-014/016 priority order applies.
REQ-024 SHALL have all arithmetic as 8-bit bitwise XOR; no carries, no wrap concerns.

Reset
REQ-025 SHALL, while rst = 1, force dout, hdr, hold_byte, int_parity, pkt_parity = 8'h00 and parity_done, lowpktvalid, err = 0, independent of clk.
REQ-026 SHALL, on rst assertion mid-packet, discard all packet state; first edge after release behaves as idle with zeroed registers.

Verification
REQ-027 Clean packet: header 8'h05, payload 8'hA1, parity 8'hA4 (pktvalid low) -> dout sequence 05, A1, A4; parity_done = 1; err = 0 next cycle.
REQ-028 Bad parity: same packet, parity byte 8'hFF -> parity_done = 1, err = 1 one cycle later; detect_add next packet clears both.
REQ-029 FIFO full mid-payload: fifofull = 1 during ld_state with datain 8'h3C -> hold_byte = 3C, dout unchanged; laf_state -> dout = 3C, int_parity includes 3C exactly once.
REQ-030 FIFO full on parity byte: ld_state & fifofull & !pktvalid with 8'hA4 -> lowpktvalid = 1; laf_state -> pkt_parity = A4, parity_done = 1; rst_int_reg clears lowpktvalid.
REQ-031 Invalid address: detect_add & pktvalid & datain = 8'h07 -> hdr unchanged, dout unchanged.
REQ-032 Async reset: assert rst between clock edges mid-payload -> all outputs 0 immediately, before next edge.
